// File: rtl/switch_outport_ctl.sv
// Purpose: per-output switch port; buffers granted flits, sends them on the link under credits, tracks wormhole state.
// Latency: a flit pushed into an empty FIFO with credit available is on flit_out with valid_out one cycle later.
// Backpressure: busy_out (registered full) stalls the allocator; zero credits hold the FIFO head.
module switch_outport_ctl #(
  parameter int FLIT_W  = 80,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 16,
  parameter int FTYPEWD = 2,
  parameter logic [FTYPEWD-1:0] ENC_PAYL = 2'b00,
  parameter logic [FTYPEWD-1:0] ENC_TAIL = 2'b01,
  parameter logic [FTYPEWD-1:0] ENC_HEAD = 2'b10,
  parameter logic [FTYPEWD-1:0] ENC_SING = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              valid_in,
  output logic              busy_out,
  output logic [FLIT_W-1:0] flit_out,
  output logic              valid_out,
  input  logic              credit_in,
  output logic              pkt_open,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);

  typedef enum logic {IDLE, OPEN} state_t;

  logic [FLIT_W-1:0]  mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic [CW-1:0]      cred;
  state_t             state;
  state_t             state_nxt;
  logic               push;
  logic               pop;
  logic               drop_err;
  logic               cred_err;
  logic               fsm_err;
  logic [FTYPEWD-1:0] in_type;
  logic [FTYPEWD-1:0] out_type;

  // Full and credit decodes come only from registered state, so there is no path from valid_in/credit_in to busy_out.
  assign busy_out  = (count == FULL_CNT);
  assign valid_out = (count != '0) && (cred != '0);
  assign push      = valid_in && !busy_out;
  assign pop       = valid_out;
  assign flit_out  = mem[rd_ptr];
  assign in_type   = flit_in[FTYPEWD-1:0];
  assign out_type  = flit_out[FTYPEWD-1:0];

  // A flit arriving while full is dropped; a credit beyond the downstream depth is ignored.
  assign drop_err  = valid_in && busy_out;
  assign cred_err  = credit_in && !pop && (cred == CRED_MAX);

  // FIFO storage: written at the write pointer on push, cleared on reset so flit_out reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= flit_in;
    end
  end

  // Pointers wrap naturally; count tracks occupancy and is unchanged on simultaneous push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Credit counter: pop consumes, credit_in returns, both together cancel, saturates at CREDITS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cred <= CRED_MAX;
    end else if (pop && !credit_in) begin
      cred <= cred - CRED_ONE;
    end else if (!pop && credit_in && (cred != CRED_MAX)) begin
      cred <= cred + CRED_ONE;
    end
  end

  // Packet state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Packet next state: only accepted flits advance it; illegal types leave it where it was.
  always_comb begin
    state_nxt = state;
    if (push) begin
      case (state)
        IDLE:    if (in_type == ENC_HEAD) state_nxt = OPEN;
        OPEN:    if (in_type == ENC_TAIL) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Packet outputs: open flag, and a type violation on an accepted flit.
  always_comb begin
    pkt_open = (state == OPEN);
    fsm_err  = 1'b0;
    if (push) begin
      if (state == IDLE)
        fsm_err = (in_type == ENC_PAYL) || (in_type == ENC_TAIL);
      else
        fsm_err = (in_type == ENC_HEAD) || (in_type == ENC_SING);
    end
  end

  // Completed packets are counted when their last flit leaves on the link.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count <= '0;
    end else if (pop && ((out_type == ENC_TAIL) || (out_type == ENC_SING))) begin
      pkt_count <= pkt_count + CNT_W'(1);
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (drop_err || cred_err || fsm_err) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_switch_outport_ctl.sv
// Bench for switch_outport_ctl: vector table, directed corner sequences, randomized traffic against a queue model.
module tb_switch_outport_ctl;
  localparam int FLIT_W  = 80;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;
  localparam int CNT_W   = 16;
  localparam logic [1:0] T_PAYL = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_SING = 2'b11;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [FLIT_W-1:0] flit_in = '0;
  logic              valid_in = 1'b0;
  logic              credit_in = 1'b0;
  logic              busy_out;
  logic [FLIT_W-1:0] flit_out;
  logic              valid_out;
  logic              pkt_open;
  logic [CNT_W-1:0]  pkt_count;
  logic              proto_err;

  always #5 clk = ~clk;

  switch_outport_ctl #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .valid_in(valid_in), .busy_out(busy_out),
    .flit_out(flit_out), .valid_out(valid_out), .credit_in(credit_in),
    .pkt_open(pkt_open), .pkt_count(pkt_count), .proto_err(proto_err)
  );

  int n_checks = 0;
  int n_err    = 0;
  int pops_seen;

  // Reference model: FIFO as a queue, plain integer credit count, open flag.
  logic [FLIT_W-1:0] q[$];
  int m_cred;
  bit m_open;
  int m_pkt;
  bit m_err;

  typedef struct {
    bit         vin;
    logic [1:0] ft;
    bit         cin;
    bit         e_valid;
    bit         e_busy;
    bit         e_open;
    int         e_cnt;
    bit         e_err;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mkflit(input int id, input logic [1:0] t);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[FLIT_W-1:FLIT_W-32] = $urandom;
    f[33:2] = id;
    f[1:0]  = t;
    return f;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cred = CREDITS;
    m_open = 1'b0;
    m_pkt  = 0;
    m_err  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  128'(busy_out),  128'(0));
    chk({tag, "_valid"}, 128'(valid_out), 128'(0));
    chk({tag, "_flit"},  128'(flit_out),  128'(0));
    chk({tag, "_open"},  128'(pkt_open),  128'(0));
    chk({tag, "_pktc"},  128'(pkt_count), 128'(0));
    chk({tag, "_err"},   128'(proto_err), 128'(0));
  endtask

  // One clock cycle, entered and left at posedge+1: drive, compare against model, advance model and DUT.
  task automatic cycle(input bit vin, input logic [FLIT_W-1:0] f, input bit cin);
    bit e_valid;
    bit e_busy;
    logic [1:0] t;
    valid_in  = vin;
    flit_in   = f;
    credit_in = cin;
    #1;
    e_busy  = (q.size() == DEPTH);
    e_valid = (q.size() != 0) && (m_cred != 0);
    chk("m_busy",  128'(busy_out),  128'(e_busy));
    chk("m_valid", 128'(valid_out), 128'(e_valid));
    chk("m_open",  128'(pkt_open),  128'(m_open));
    chk("m_pktc",  128'(pkt_count), 128'(m_pkt));
    chk("m_err",   128'(proto_err), 128'(m_err));
    if (e_valid) chk("m_flit", 128'(flit_out), 128'(q[0]));
    if (valid_out) pops_seen++;
    if (e_valid) begin
      t = q[0][1:0];
      if (t == T_TAIL || t == T_SING) m_pkt = (m_pkt + 1) % (1 << CNT_W);
      void'(q.pop_front());
      m_cred--;
    end
    if (vin) begin
      if (e_busy) begin
        m_err = 1'b1;
      end else begin
        q.push_back(f);
        t = f[1:0];
        if (!m_open) begin
          if (t == T_HEAD) m_open = 1'b1;
          else if (t != T_SING) m_err = 1'b1;
        end else begin
          if (t == T_TAIL) m_open = 1'b0;
          else if (t != T_PAYL) m_err = 1'b1;
        end
      end
    end
    if (cin) begin
      if (e_valid) m_cred++;
      else if (m_cred == CREDITS) m_err = 1'b1;
      else m_cred++;
    end
    @(posedge clk);
    #1;
  endtask

  // Reset pulse started mid-cycle; outputs must be at reset values before any clock edge.
  task automatic do_reset(input string tag);
    valid_in  = 1'b0;
    credit_in = 1'b0;
    flit_in   = '0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [FLIT_W-1:0] fl[9];
    logic [FLIT_W-1:0] f;
    int sent;
    int given;
    int ds;
    int id;
    bit vin;
    bit cin;
    bit popm;
    logic [1:0] t;

    // Expected outputs just after the edge that consumes each row's inputs.
    tbl[0]  = '{1'b1, T_SING, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    tbl[1]  = '{1'b0, T_PAYL, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    tbl[2]  = '{1'b1, T_HEAD, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0};
    tbl[3]  = '{1'b1, T_PAYL, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0};
    tbl[4]  = '{1'b1, T_TAIL, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    tbl[5]  = '{1'b0, T_PAYL, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    tbl[6]  = '{1'b0, T_PAYL, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    tbl[7]  = '{1'b0, T_PAYL, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    tbl[8]  = '{1'b0, T_PAYL, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    tbl[9]  = '{1'b0, T_PAYL, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    tbl[10] = '{1'b0, T_PAYL, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1};
    tbl[11] = '{1'b1, T_TAIL, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1};

    model_reset();
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Table: basic latency, packet flow, credit return and saturation error.
    for (int i = 0; i < 12; i++) begin
      f = mkflit(i + 100, tbl[i].ft);
      valid_in  = tbl[i].vin;
      flit_in   = f;
      credit_in = tbl[i].cin;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 128'(valid_out), 128'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_busy", i),  128'(busy_out),  128'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_open", i),  128'(pkt_open),  128'(tbl[i].e_open));
      chk($sformatf("tbl%0d_pktc", i),  128'(pkt_count), 128'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_err", i),   128'(proto_err), 128'(tbl[i].e_err));
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_flit", i), 128'(flit_out), 128'(f));
    end

    // Fill and stall: 9-flit packet with no credits returned.
    do_reset("rst_fill");
    fl[0] = mkflit(200, T_HEAD);
    for (int i = 1; i < 8; i++) fl[i] = mkflit(200 + i, T_PAYL);
    fl[8] = mkflit(208, T_TAIL);
    sent = 0;
    pops_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (sent < 9 && !busy_out) begin
        cycle(1'b1, fl[sent], 1'b0);
        sent++;
      end else begin
        cycle(1'b0, '0, 1'b0);
      end
    end
    chk("fill_pops",  128'(pops_seen), 128'(4));
    chk("fill_valid", 128'(valid_out), 128'(0));
    chk("fill_busy",  128'(busy_out),  128'(1));
    chk("fill_open",  128'(pkt_open),  128'(1));
    chk("fill_sent",  128'(sent),      128'(8));

    // Drain with five single credit pulses.
    given = 0;
    for (int c = 0; c < 40; c++) begin
      cin = (given < 5) && (c % 4 == 0);
      if (cin) given++;
      if (sent < 9 && !busy_out) begin
        cycle(1'b1, fl[sent], cin);
        sent++;
      end else begin
        cycle(1'b0, '0, cin);
      end
    end
    chk("drain_pops", 128'(pops_seen), 128'(9));
    chk("drain_sent", 128'(sent),      128'(9));
    chk("drain_pktc", 128'(pkt_count), 128'(1));
    chk("drain_open", 128'(pkt_open),  128'(0));
    chk("drain_err",  128'(proto_err), 128'(0));
    chk("drain_busy", 128'(busy_out),  128'(0));

    // Simultaneous push, pop and credit at count 2, cred 1.
    do_reset("rst_sim");
    cycle(1'b1, mkflit(300, T_HEAD), 1'b0);
    for (int i = 1; i < 6; i++) cycle(1'b1, mkflit(300 + i, T_PAYL), 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("sim_pre_count", 128'(dut.count), 128'(2));
    chk("sim_pre_cred",  128'(dut.cred),  128'(1));
    cycle(1'b1, mkflit(310, T_PAYL), 1'b1);
    chk("sim_count", 128'(dut.count), 128'(2));
    chk("sim_cred",  128'(dut.cred),  128'(1));

    // Async reset mid-packet with three flits buffered.
    cycle(1'b1, mkflit(311, T_PAYL), 1'b0);
    cycle(1'b1, mkflit(312, T_PAYL), 1'b0);
    chk("ar_pre_count", 128'(dut.count), 128'(3));
    chk("ar_pre_open",  128'(pkt_open),  128'(1));
    valid_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("ar");
    @(posedge clk);
    #1;
    check_reset_outputs("ar_hold");
    rst = 1'b0;
    model_reset();
    chk("ar_busy", 128'(busy_out), 128'(0));
    chk("ar_cred", 128'(dut.cred), 128'(CREDITS));

    // Error: TAIL while idle, sticky.
    cycle(1'b1, mkflit(400, T_TAIL), 1'b0);
    for (int c = 0; c < 3; c++) cycle(1'b0, '0, 1'b0);
    chk("err_tail_sticky", 128'(proto_err), 128'(1));

    // Error: valid_in while busy; the flit must not be stored.
    do_reset("rst_busy");
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      if (sent < 8 && !busy_out) begin
        cycle(1'b1, mkflit(500 + sent, T_SING), 1'b0);
        sent++;
      end else begin
        cycle(1'b0, '0, 1'b0);
      end
    end
    chk("busy_full", 128'(busy_out), 128'(1));
    chk("busy_err0", 128'(proto_err), 128'(0));
    cycle(1'b1, mkflit(599, T_SING), 1'b0);
    chk("busy_err1",  128'(proto_err), 128'(1));
    chk("busy_count", 128'(dut.count), 128'(4));
    given = 0;
    for (int c = 0; c < 16; c++) begin
      cin = (given < 4) && (c % 3 == 0);
      if (cin) given++;
      cycle(1'b0, '0, cin);
    end
    chk("busy_pktc", 128'(pkt_count), 128'(8));

    // Randomized legal traffic with a downstream that returns credits at random.
    do_reset("rst_rand");
    ds = 0;
    id = 1000;
    for (int c = 0; c < 600; c++) begin
      vin = (q.size() != DEPTH) && ($urandom_range(3) != 0);
      if (!m_open) t = ($urandom_range(1) == 0) ? T_HEAD : T_SING;
      else         t = ($urandom_range(9) < 6) ? T_PAYL : T_TAIL;
      cin  = (ds > 0) && ($urandom_range(1) == 1);
      popm = (q.size() != 0) && (m_cred != 0);
      cycle(vin, mkflit(id, t), cin);
      id++;
      ds = ds + (popm ? 1 : 0) - (cin ? 1 : 0);
    end
    chk("rand_err", 128'(proto_err), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
